// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram read-modify-write controller.
package hist_pkg;

    localparam int unsigned ADDR_W_DEF   = 12;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned WEIGHT_W_DEF = 8;
    localparam int unsigned BE_MAX_W     = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UPD_RD  = 3'd1,
        UPD_WB  = 3'd2,
        CLR     = 3'd3,
        HRD_RD  = 3'd4,
        HRD_CAP = 3'd5
    } state_t;

    // Byte-enable with one bit set per byte of a data_w-wide word.
    function automatic logic [BE_MAX_W-1:0] all_ones_be(input int unsigned data_w);
        logic [BE_MAX_W-1:0] be;
        be = '0;
        for (int unsigned i = 0; i < BE_MAX_W; i++) begin
            if (i < data_w / 8) be[i] = 1'b1;
        end
        return be;
    endfunction

endpackage

// File: rtl/hist_rmw_ctrl_sat_add.sv
// Combinational saturating adder: bin counter plus sample weight, clamped at all-ones.
module hist_sat_add
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned WEIGHT_W = WEIGHT_W_DEF
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [WEIGHT_W-1:0] b,
    output logic [DATA_W-1:0]   sum_c
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide  = {1'b0, a} + (DATA_W+1)'(b);
        sum_c = wide[DATA_W] ? '1 : wide[DATA_W-1:0];
    end

endmodule

// File: rtl/hist_rmw_ctrl.sv
// Histogram store sequencer: saturating sample updates, clear sweep and host
// readback, all arbitrated onto one single-port SRAM with 1-cycle read latency.
module hist_rmw_ctrl
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned WEIGHT_W       = WEIGHT_W_DEF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    input  logic [ADDR_W-1:0]     bin_idx,
    input  logic [WEIGHT_W-1:0]   bin_weight,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  rd_req,
    output logic                  rd_ready,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_clken,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int unsigned BE_W      = DATA_W / 8;
    localparam state_t      RST_STATE = CLEAR_ON_RESET ? CLR : IDLE;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic                clear_pending, rd_pending;
    logic [ADDR_W-1:0]   idx_q, rd_addr_q;
    logic [WEIGHT_W-1:0] weight_q;
    logic [DATA_W-1:0]   sum_c;

    logic decision, cnt_last, take_sample, clr_accept, rd_accept, take_rd_new;

    assign decision    = (state == IDLE) || (state == UPD_WB);
    assign cnt_last    = &cnt;
    assign bin_ready   = decision && !clear_pending && !rd_pending;
    assign rd_ready    = !rd_pending && (state != HRD_RD) && (state != HRD_CAP);
    assign clear_busy  = clear_pending || (state == CLR);
    assign take_sample = bin_valid && bin_ready;
    assign clr_accept  = clear_start && !clear_busy;
    assign rd_accept   = rd_req && rd_ready;
    // A fresh host read at an otherwise free decision point skips the pending flag.
    assign take_rd_new = bin_ready && !bin_valid && !clr_accept && rd_accept;

    assign mem_clken      = 1'b1;
    assign mem_byteenable = BE_W'(all_ones_be(DATA_W));

    hist_sat_add #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W)
    ) u_sat_add (
        .a     (mem_readdata),
        .b     (weight_q),
        .sum_c (sum_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RST_STATE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, UPD_WB: begin
                if (clear_pending)                   state_nxt = CLR;
                else if (rd_pending || take_rd_new) state_nxt = HRD_RD;
                else if (take_sample)                state_nxt = UPD_RD;
                else                                 state_nxt = IDLE;
            end
            UPD_RD:  state_nxt = UPD_WB;
            CLR:     if (cnt_last) state_nxt = IDLE;
            HRD_RD:  state_nxt = HRD_CAP;
            HRD_CAP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        case (state)
            UPD_RD: begin
                mem_chipselect = 1'b1;
                mem_address    = idx_q;
            end
            UPD_WB: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = idx_q;
                mem_writedata  = sum_c;
            end
            CLR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = cnt;
            end
            HRD_RD: begin
                mem_chipselect = 1'b1;
                mem_address    = rd_addr_q;
            end
            default: ;
        endcase
    end

    // Request latches, sweep counter and registered host-side results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            clear_pending <= 1'b0;
            rd_pending    <= 1'b0;
            idx_q         <= '0;
            weight_q      <= '0;
            rd_addr_q     <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            clear_done    <= 1'b0;
        end else begin
            rd_valid   <= (state == HRD_CAP);
            clear_done <= (state == CLR) && cnt_last;
            if (state == HRD_CAP) rd_data <= mem_readdata;

            if (state == CLR) cnt <= cnt + ADDR_W'(1);
            else              cnt <= '0;

            if (take_sample) begin
                idx_q    <= bin_idx;
                weight_q <= bin_weight;
            end
            if (rd_accept) rd_addr_q <= rd_addr;

            if (clr_accept)                     clear_pending <= 1'b1;
            else if (decision && clear_pending) clear_pending <= 1'b0;

            if (rd_accept && !take_rd_new)                      rd_pending <= 1'b1;
            else if (decision && !clear_pending && rd_pending)  rd_pending <= 1'b0;
        end
    end

endmodule
